// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C target types and constants
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_BYTE_W = 8;

  localparam logic I2C_RD = 1'b1;
  localparam logic I2C_WR = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    TX,
    MACK,
    WAIT_STOP
  } i2c_state_e;

endpackage

// File: rtl/i2c_bus_sync.sv
// rtl/i2c_bus_sync.sv - SCL/SDA synchronizer with registered edge and START/STOP events
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sr;
  logic [SYNC_STAGES-1:0] sda_sr;
  logic                   scl_p;
  logic                   sda_p;
  logic                   scl_s;
  logic                   sda_s;

  assign scl_s = scl_sr[SYNC_STAGES-1];
  assign sda_s = sda_sr[SYNC_STAGES-1];

  // scl/sda come from the previous-value register so they line up with the event pulses
  assign scl = scl_p;
  assign sda = sda_p;

  // Chains reset to the idle-high bus level so leaving reset creates no START/STOP
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_sr    <= '1;
      sda_sr    <= '1;
      scl_p     <= 1'b1;
      sda_p     <= 1'b1;
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
    end else begin
      scl_sr    <= {scl_sr[SYNC_STAGES-2:0], scl_in};
      sda_sr    <= {sda_sr[SYNC_STAGES-2:0], sda_in};
      scl_p     <= scl_s;
      sda_p     <= sda_s;
      scl_rise  <= scl_s & ~scl_p;
      scl_fall  <= ~scl_s & scl_p;
      start_det <= scl_s & scl_p & sda_p & ~sda_s;
      stop_det  <= scl_s & scl_p & ~sda_p & sda_s;
    end
  end

endmodule

// File: rtl/i2c_slave_tx.sv
// rtl/i2c_slave_tx.sv - I2C target transmitter serving master reads from a byte source
module i2c_slave_tx import i2c_pkg::*; #(
  parameter logic [I2C_ADDR_W-1:0] ADDR        = 7'd27,
  parameter int                    SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  scl_in,
  input  logic                  sda_in,
  output logic                  sda_oe,
  input  logic [I2C_BYTE_W-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  underrun,
  output logic                  addr_hit,
  output logic                  master_nack,
  output logic                  busy
);

  logic scl;
  logic sda;
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  i2c_bus_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .reset     (reset),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .scl       (scl),
    .sda       (sda),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  i2c_state_e            state, state_n;
  logic [3:0]            bit_cnt, cnt_n;
  logic [I2C_BYTE_W-1:0] shift_reg, shift_n;
  logic [I2C_BYTE_W-1:0] load_byte;
  logic                  oe_n;
  logic                  do_load;
  logic                  tx_ready_n, underrun_n, addr_hit_n, nack_n;
  logic                  scl_unused;

  assign scl_unused = scl;
  assign busy       = (state != IDLE);
  assign load_byte  = tx_valid ? tx_data : 8'hFF;

  always_comb begin
    state_n    = state;
    cnt_n      = bit_cnt;
    shift_n    = shift_reg;
    oe_n       = sda_oe;
    do_load    = 1'b0;
    tx_ready_n = 1'b0;
    underrun_n = 1'b0;
    addr_hit_n = 1'b0;
    nack_n     = 1'b0;

    if (stop_det) begin
      state_n = IDLE;
      oe_n    = 1'b0;
    end else if (start_det) begin
      state_n = i2c_pkg::ADDR;
      cnt_n   = 4'd0;
      oe_n    = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
        end
        i2c_pkg::ADDR: begin
          if (scl_rise) begin
            shift_n = {shift_reg[6:0], sda};
            cnt_n   = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            cnt_n = 4'd0;
            if (shift_reg[7:1] == ADDR && shift_reg[0] == I2C_RD) begin
              oe_n       = 1'b1;
              addr_hit_n = 1'b1;
              state_n    = ADDR_ACK;
            end else begin
              state_n = WAIT_STOP;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) do_load = 1'b1;
        end
        TX: begin
          if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              oe_n    = 1'b0;
              cnt_n   = 4'd0;
              state_n = MACK;
            end else begin
              shift_n = {shift_reg[6:0], 1'b1};
              oe_n    = ~shift_reg[6];
              cnt_n   = bit_cnt + 4'd1;
            end
          end
        end
        MACK: begin
          // A NACK leaves the state, so a fall seen here always follows an ACK
          if (scl_rise && sda) begin
            nack_n  = 1'b1;
            state_n = WAIT_STOP;
          end else if (scl_fall) begin
            do_load = 1'b1;
          end
        end
        WAIT_STOP: begin
          oe_n = 1'b0;
        end
        default: begin
          state_n = IDLE;
          oe_n    = 1'b0;
        end
      endcase
    end

    // bit_cnt counts bits already put on the bus, so bit 7 counts as one
    if (do_load) begin
      shift_n    = load_byte;
      oe_n       = ~load_byte[7];
      tx_ready_n = 1'b1;
      underrun_n = ~tx_valid;
      cnt_n      = 4'd1;
      state_n    = TX;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      bit_cnt     <= 4'd0;
      shift_reg   <= 8'hFF;
      sda_oe      <= 1'b0;
      tx_ready    <= 1'b0;
      underrun    <= 1'b0;
      addr_hit    <= 1'b0;
      master_nack <= 1'b0;
    end else begin
      state       <= state_n;
      bit_cnt     <= cnt_n;
      shift_reg   <= shift_n;
      sda_oe      <= oe_n;
      tx_ready    <= tx_ready_n;
      underrun    <= underrun_n;
      addr_hit    <= addr_hit_n;
      master_nack <= nack_n;
    end
  end

endmodule

// File: tb/tb_i2c_slave_tx.sv
// tb/tb_i2c_slave_tx.sv - directed bench for i2c_slave_tx using a bit-banged bus master
module tb_i2c_slave_tx;

  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       scl_in = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_in;
  logic       sda_oe;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       underrun;
  logic       addr_hit;
  logic       master_nack;
  logic       busy;

  assign sda_in = sda_m & ~sda_oe;

  i2c_slave_tx #(
    .ADDR        (7'd27),
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .scl_in      (scl_in),
    .sda_in      (sda_in),
    .sda_oe      (sda_oe),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .underrun    (underrun),
    .addr_hit    (addr_hit),
    .master_nack (master_nack),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_rdy = 0, n_und = 0, n_hit = 0, n_nack = 0, n_both = 0;
  always @(negedge clk) begin
    if (tx_ready) n_rdy++;
    if (underrun) n_und++;
    if (addr_hit) n_hit++;
    if (master_nack) n_nack++;
    if (tx_ready && addr_hit) n_both++;
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic qwait(input int n);
    repeat (n * Q) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; qwait(1);
    scl_in = 1'b1; qwait(1);
    sda_m = 1'b0; qwait(1);
    scl_in = 1'b0; qwait(1);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; qwait(1);
    scl_in = 1'b1; qwait(1);
    sda_m = 1'b1; qwait(1);
  endtask

  task automatic bit_x(input logic m, output logic line, output logic oe);
    sda_m = m; qwait(1);
    scl_in = 1'b1; qwait(1);
    line = sda_in;
    oe = sda_oe;
    qwait(1);
    scl_in = 1'b0; qwait(1);
  endtask

  task automatic send_addr(input logic [6:0] a, input logic rw, output logic ack);
    logic [7:0] b;
    logic l, o;
    b = {a, rw};
    for (int i = 7; i >= 0; i--) bit_x(b[i], l, o);
    bit_x(1'b1, ack, o);
  endtask

  task automatic read_bits(input int n, output logic [7:0] b);
    logic l, o;
    b = 8'h00;
    for (int i = 0; i < n; i++) begin
      bit_x(1'b1, l, o);
      b = {b[6:0], l};
    end
  endtask

  logic       ack, line, oe;
  logic [7:0] rd;
  int b_rdy, b_und, b_hit, b_nack;

  task automatic snap();
    b_rdy = n_rdy; b_und = n_und; b_hit = n_hit; b_nack = n_nack;
  endtask

  initial begin
    // reset state
    repeat (4) @(negedge clk);
    check("rst_sda_oe", 32'(sda_oe), 32'd0);
    check("rst_tx_ready", 32'(tx_ready), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_addr_hit", 32'(addr_hit), 32'd0);
    check("rst_master_nack", 32'(master_nack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    qwait(2);

    // single byte read, A5, master NACK
    snap();
    tx_data = 8'hA5; tx_valid = 1'b1;
    bus_start();
    check("t1_busy_after_start", 32'(busy), 32'd1);
    send_addr(7'd27, 1'b1, ack);
    check("t1_addr_ack", 32'(ack), 32'd0);
    read_bits(8, rd);
    check("t1_byte", 32'(rd), 32'hA5);
    bit_x(1'b1, line, oe);
    check("t1_mack_slot_oe", 32'(oe), 32'd0);
    bus_stop();
    qwait(1);
    check("t1_busy_after_stop", 32'(busy), 32'd0);
    check("t1_addr_hit_cnt", 32'(n_hit - b_hit), 32'd1);
    check("t1_tx_ready_cnt", 32'(n_rdy - b_rdy), 32'd1);
    check("t1_nack_cnt", 32'(n_nack - b_nack), 32'd1);
    check("t1_underrun_cnt", 32'(n_und - b_und), 32'd0);

    // three byte read: ACK, ACK, NACK
    snap();
    tx_data = 8'h01;
    bus_start();
    send_addr(7'd27, 1'b1, ack);
    check("t2_addr_ack", 32'(ack), 32'd0);
    read_bits(8, rd);
    check("t2_byte0", 32'(rd), 32'h01);
    tx_data = 8'h80;
    bit_x(1'b0, line, oe);
    check("t2_mack0_oe", 32'(oe), 32'd0);
    read_bits(8, rd);
    check("t2_byte1", 32'(rd), 32'h80);
    tx_data = 8'hFF;
    bit_x(1'b0, line, oe);
    check("t2_mack1_oe", 32'(oe), 32'd0);
    read_bits(8, rd);
    check("t2_byte2", 32'(rd), 32'hFF);
    bit_x(1'b1, line, oe);
    check("t2_mack2_oe", 32'(oe), 32'd0);
    bus_stop();
    qwait(1);
    check("t2_tx_ready_cnt", 32'(n_rdy - b_rdy), 32'd3);
    check("t2_nack_cnt", 32'(n_nack - b_nack), 32'd1);
    check("t2_busy", 32'(busy), 32'd0);

    // wrong address, then write direction: no ACK, no pulses
    snap();
    bus_start();
    send_addr(7'd26, 1'b1, ack);
    check("t3_addr26_ack", 32'(ack), 32'd1);
    read_bits(8, rd);
    check("t3_addr26_idle_bus", 32'(rd), 32'hFF);
    check("t3_addr26_busy", 32'(busy), 32'd1);
    bus_stop();
    qwait(1);
    check("t3_addr26_busy_stop", 32'(busy), 32'd0);
    bus_start();
    send_addr(7'd27, 1'b0, ack);
    check("t3_write_ack", 32'(ack), 32'd1);
    check("t3_write_busy", 32'(busy), 32'd1);
    bus_stop();
    qwait(1);
    check("t3_write_busy_stop", 32'(busy), 32'd0);
    check("t3_hit_cnt", 32'(n_hit - b_hit), 32'd0);
    check("t3_rdy_cnt", 32'(n_rdy - b_rdy), 32'd0);

    // underrun: no valid byte at load time
    snap();
    tx_valid = 1'b0; tx_data = 8'h00;
    bus_start();
    send_addr(7'd27, 1'b1, ack);
    check("t4_addr_ack", 32'(ack), 32'd0);
    read_bits(8, rd);
    check("t4_byte_ff", 32'(rd), 32'hFF);
    bit_x(1'b1, line, oe);
    bus_stop();
    qwait(1);
    check("t4_underrun_cnt", 32'(n_und - b_und), 32'd1);
    check("t4_tx_ready_cnt", 32'(n_rdy - b_rdy), 32'd1);

    // repeated START after 4 bits, then STOP mid-byte
    snap();
    tx_valid = 1'b1; tx_data = 8'h5A;
    bus_start();
    send_addr(7'd27, 1'b1, ack);
    check("t5_addr_ack", 32'(ack), 32'd0);
    read_bits(4, rd);
    check("t5_nibble", 32'(rd), 32'h05);
    tx_data = 8'hC3;
    bus_start();
    check("t5_rs_oe", 32'(sda_oe), 32'd0);
    check("t5_rs_busy", 32'(busy), 32'd1);
    send_addr(7'd27, 1'b1, ack);
    check("t5_rs_ack", 32'(ack), 32'd0);
    read_bits(8, rd);
    check("t5_rs_byte", 32'(rd), 32'hC3);
    tx_data = 8'hFF;
    bit_x(1'b0, line, oe);
    read_bits(3, rd);
    check("t5_partial", 32'(rd), 32'h07);
    bus_stop();
    qwait(1);
    check("t5_stop_busy", 32'(busy), 32'd0);
    check("t5_stop_oe", 32'(sda_oe), 32'd0);
    check("t5_hit_cnt", 32'(n_hit - b_hit), 32'd2);
    check("t5_rdy_cnt", 32'(n_rdy - b_rdy), 32'd3);
    check("t5_both_high", 32'(n_both), 32'd0);

    // asynchronous reset while driving a 0 bit, then a clean read
    tx_data = 8'h00;
    bus_start();
    send_addr(7'd27, 1'b1, ack);
    check("t6_drive_low", 32'(sda_oe), 32'd1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1 check("t6_async_release", 32'(sda_oe), 32'd0);
    @(negedge clk);
    check("t6_reset_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    qwait(2);
    bus_stop();
    qwait(1);
    snap();
    tx_data = 8'h3C;
    bus_start();
    send_addr(7'd27, 1'b1, ack);
    check("t6_addr_ack", 32'(ack), 32'd0);
    read_bits(8, rd);
    check("t6_byte", 32'(rd), 32'h3C);
    bit_x(1'b1, line, oe);
    bus_stop();
    qwait(1);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_nack_cnt", 32'(n_nack - b_nack), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i2c_slave_tx.md
# i2c_slave_tx

I2C target-side transmitter: serves master read transactions by returning bytes from a parallel source over the open-drain SDA line. It complements the existing receive-side `i2c` target, which turns master writes into parallel data. It sits between the bus pins (through external open-drain pads) and a local byte producer, and runs entirely on the system clock, oversampling SCL and SDA.

## Interface
- `ADDR`, 7'd27: 7-bit target address this block responds to.
- `SYNC_STAGES`, 2: synchronizer depth on `scl_in`/`sda_in`; minimum 2.
- `clk` input 1: system clock; must be ≥16× the SCL frequency.
- `reset` input 1: asynchronous, active-low reset (0 = reset).
- `scl_in` input 1: bus SCL level, asynchronous.
- `sda_in` input 1: bus SDA level, asynchronous.
- `sda_oe` output 1: 1 = pull SDA low; 0 = release. Registered.
- `tx_data` input 8: next byte to transmit.
- `tx_valid` input 1: `tx_data` holds a byte.
- `tx_ready` output 1: one-cycle pulse when a byte is loaded; `tx_data` is consumed if `tx_valid` = 1 in that cycle.
- `underrun` output 1: one-cycle pulse when a load occurs with `tx_valid` = 0.
- `addr_hit` output 1: one-cycle pulse when the address matches with R/W = 1 and ACK is driven.
- `master_nack` output 1: one-cycle pulse on master NACK after a data byte.
- `busy` output 1: high in every state except IDLE.

## Operation
- Events are taken from synchronized, edge-detected signals: SCL rise, SCL fall, START (SDA fall while SCL high), STOP (SDA rise while SCL high).
- States:
  - IDLE: on START, go to ADDR.
  - ADDR: shift 8 bits MSB first on SCL rise (7 address bits, then R/W). On the SCL fall after the 8th bit:
    - match and R/W = 1: set `sda_oe` = 1, pulse `addr_hit`, go to ADDR_ACK.
    - otherwise: go to WAIT_STOP. `sda_oe` stays 0, so no ACK is given; write transactions belong to the receiver.
  - ADDR_ACK: on the next SCL fall, load the shift register and pulse `tx_ready`.
    - Source is `tx_data` if `tx_valid` = 1; otherwise 8'hFF with an `underrun` pulse.
    - Drive bit 7 (`sda_oe` = ~bit) and go to TX.
  - TX: on each SCL fall, shift and drive the next bit.
    - On the fall ending the 8th bit, set `sda_oe` = 0 and go to MACK.
  - MACK: sample SDA on SCL rise.
    - 0 (ACK): on the following SCL fall, load the next byte as in ADDR_ACK and go to TX.
    - 1 (NACK): pulse `master_nack`, go to WAIT_STOP.
  - WAIT_STOP: `sda_oe` = 0; ignore SCL.
- STOP in any state: go to IDLE, set `sda_oe` = 0 in the next cycle.
- START in any state (repeated START): clear the bit counter, set `sda_oe` = 0, go to ADDR.
- START/STOP take priority over SCL edges detected in the same cycle.
- Bit counter: 4 bits, resets to 0 at START and at each byte boundary. No clock stretching; SCL is never driven.

## Timing
- Reset values: `sda_oe` = 0, `tx_ready` = 0, `underrun` = 0, `addr_hit` = 0, `master_nack` = 0, `busy` = 0; state = IDLE; shift register = 8'hFF.
- Input latency: pin edge to detected event is `SYNC_STAGES` + 1 clk.
- `sda_oe` changes in the clk cycle after the detected SCL fall. Total delay from pin SCL fall to `sda_oe` is `SYNC_STAGES` + 2 clk, which is well inside SCL low time at ≥16× oversampling.
- `sda_oe` only changes in response to SCL fall, START, STOP, or reset, so the block never creates a false START/STOP.
- `tx_ready`, `underrun`, `addr_hit`, and `master_nack` are exactly 1 clk wide.
- `tx_ready` and `addr_hit` are never high in the same cycle.
- Reset mid-transfer releases SDA immediately (asynchronous). After release the block waits in IDLE for a fresh START.

## Structure
- Package `i2c_pkg`:
  - state enum {IDLE, ADDR, ADDR_ACK, TX, MACK, WAIT_STOP};
  - `I2C_ADDR_W` = 7, `I2C_BYTE_W` = 8;
  - R/W encoding constants `I2C_RD` = 1 and `I2C_WR` = 0, shared with the receiver.
- Sub-module `i2c_bus_sync`: `SYNC_STAGES` flops per line plus a previous-value register. It outputs `scl_rise`, `scl_fall`, `start_det`, `stop_det`, and synchronized `sda`/`scl`. The receiver reuses it.

## Test plan
- Read 1 byte: START, address 27 + R, `tx_data` = 8'hA5 with `tx_valid`, master NACK, STOP → ACK low on 9th SCL, SDA = 1010_0101, then `addr_hit`, 1 `tx_ready`, `master_nack` pulses, `busy` falls after STOP.
- Read 3 bytes 8'h01, 8'h80, 8'hFF, master ACK, ACK, NACK → 3 `tx_ready` pulses, bits match MSB first, `sda_oe` = 0 during every master ACK slot.
- Address 26 + R, then address 27 + W → no ACK in either case (`sda_oe` stays 0), no pulses, WAIT_STOP until STOP.
- `tx_valid` = 0 at load → 8'hFF on bus (`sda_oe` = 0 all 8 bits), `underrun` pulses once.
- Repeated START after 4 data bits, then address 27 + R → `sda_oe` released, new ACK, fresh byte loaded. STOP mid-byte → IDLE, `sda_oe` = 0.
- Assert `reset` = 0 while driving a 0 bit → `sda_oe` = 0 asynchronously. Deassert, then a clean read of 8'h3C succeeds.
